wb_crc32: RTL
=============

// Module: wb_crc32
// PURPOSE
//  Pipelined Wishbone B4 slave CRC-32 accelerator (IEEE 802.3, reflected) on the shared-bus interconnect next to the RAM.
//  Core data port writes payload bytes, engine folds them into the running CRC, core reads the finished checksum.
//  Offloads the crc_32 software loop; bus stall is the only flow control.
// PARAMETERS
//  POLY     32'hEDB88320  reflected generator polynomial
//  INIT     32'hFFFFFFFF  CRC register value after reset / CTRL.INIT
//  XOR_OUT  32'hFFFFFFFF  XOR applied to the CRC register on CRC reads
// PORTS
//  clk       in   1   clock, all logic on rising edge
//  rst_n     in   1   asynchronous active-low reset
//  wb_cyc    in   1   bus cycle
//  wb_stb    in   1   request strobe
//  wb_we     in   1   1=write
//  wb_adr    in   32  byte address; only [3:2] decoded
//  wb_sel    in   4   byte enables
//  wb_dat_i  in   32  write data
//  wb_dat_o  out  32  read data, valid with wb_ack
//  wb_ack    out  1   one-cycle acknowledge
//  wb_stall  out  1   request not accepted this cycle
//  wb_err    out  1   tied 0
// BEHAVIOUR
//  Registers (adr[3:2]):
//  0 CTRL W: bit0=1 -> crc<=INIT, byte_cnt<=0; reads 0
//  1 DATA W: queue selected bytes in order 0..3, skipping unselected; reads 0
//  2 CRC  R: crc^XOR_OUT; W: crc<=dat_i (raw seed, sel ignored)
//  3 STAT R: [0]=busy, [31:16]=byte_cnt; writes ignored
//  Accept = wb_cyc & wb_stb & ~wb_stall. wb_ack registered, high exactly one cycle after each accept.
//  wb_dat_o registered with ack; 0 otherwise. Accepted requests always acked, even if wb_cyc drops.
//  wb_stall = busy & wb_cyc & wb_stb & ~(~wb_we & adr==3). STAT reads never stall.
//  FSM: IDLE -> SHIFT on accepted DATA write with sel!=0; sel==0 write is acked, no effect.
//  SHIFT: per cycle crc<=(crc>>1)^(POLY & {32{crc[0]^d[bit]}}), bit counter 0..7 LSB first.
//  Byte done -> byte_cnt+1 (wraps 16'hFFFF->0), advance to next selected byte.
//  Last byte done -> IDLE, busy=0 the next cycle.
//  Latency: busy for 8*N cycles, N = popcount(sel); back-to-back DATA write accepted the cycle busy falls.
//  Reset (async, any state): crc=INIT, byte_cnt=0, FSM=IDLE, wb_ack=0, wb_dat_o=0, wb_stall=0.
//  Mid-operation reset drops queued bytes.
// CONFIGURATION
//  WB_CRC32_FAST_EN defined: one whole byte per cycle, 8 unrolled steps.
//   Busy for N cycles; results bit-identical.
//  Undefined: bit-serial engine as above, 8*N cycles.
// TESTING
//  reset, CTRL=1, read CRC -> 0x00000000; STAT -> 0
//  CTRL=1; DATA 0x34333231 sel F; DATA 0x38373635 sel F; DATA 0x00000039 sel 1; read CRC -> 0xCBF43926; STAT[31:16]=9
//  CTRL=1; DATA 0xAA61AAAA sel 4 -> CRC 0xE8B7BE43; same with sel 0 -> CRC 0x00000000, no busy
//  CRC read issued right after full-word DATA write -> wb_stall high 32 cycles (4 with FAST_EN); STAT reads during that time ack with busy=1
//  CTRL=1; DATA 0x00 sel 1 -> CRC 0xD202EF8D; write CRC=0x12345678 then read -> 0xEDCBA987
//  assert rst_n mid-SHIFT -> ack/stall/busy 0 immediately; after release CRC read -> 0x00000000

Source files
------------

// File: rtl/wb_crc32_if.sv
// Wishbone B4 pipelined bus bundle for the wb_crc32 slave.
// The master drives the request; the slave returns data, ack, stall and err.
interface wb_crc32_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack;
  logic        wb_stall;
  logic        wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_i,
    input  wb_dat_o, wb_ack, wb_stall, wb_err
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_i,
    output wb_dat_o, wb_ack, wb_stall, wb_err
  );
endinterface

// File: rtl/wb_crc32.sv
// Wishbone B4 pipelined CRC-32 (IEEE 802.3, reflected) accelerator slave.
// Define WB_CRC32_FAST_EN to fold one byte per cycle instead of one bit per cycle.
module wb_crc32 #(
  parameter logic [31:0] POLY    = 32'hEDB88320,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_crc32_if.slave   wb
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t      r_state;
  logic [31:0] r_crc;
  logic [31:0] r_data;
  logic [3:0]  r_sel;
  logic [15:0] r_cnt;
  logic        r_busy;
  logic        r_ack;
  logic [31:0] r_dat_o;
`ifndef WB_CRC32_FAST_EN
  logic [2:0]  r_bit;
`endif

  logic        w_stall;
  logic        w_accept;
  logic [1:0]  w_reg;
  logic [1:0]  w_idx;
  logic [7:0]  w_byte;
  logic [3:0]  w_sel_next;
  logic        w_unused;

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic d);
    return (c >> 1) ^ (POLY & {32{c[0] ^ d}});
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] t;
    t = c;
    for (int i = 0; i < 8; i++) t = crc_bit(t, b[i]);
    return t;
  endfunction

  function automatic logic [1:0] first_sel(input logic [3:0] s);
    if (s[0])      return 2'd0;
    else if (s[1]) return 2'd1;
    else if (s[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign w_reg      = wb.wb_adr[3:2];
  // STAT reads are the only requests served while the engine is busy.
  assign w_stall    = r_busy & wb.wb_cyc & wb.wb_stb & ~(~wb.wb_we & (w_reg == 2'd3));
  assign w_accept   = wb.wb_cyc & wb.wb_stb & ~w_stall;
  assign w_idx      = first_sel(r_sel);
  assign w_byte     = r_data[{w_idx, 3'b000} +: 8];
  assign w_sel_next = r_sel & ~(4'b0001 << w_idx);
  assign w_unused   = ^{wb.wb_adr[31:4], wb.wb_adr[1:0]};

  assign wb.wb_stall = w_stall;
  assign wb.wb_ack   = r_ack;
  assign wb.wb_dat_o = r_dat_o;
  assign wb.wb_err   = 1'b0;

  always_ff @(posedge clk) begin
    if (w_accept && wb.wb_we && (w_reg == 2'd1) && (wb.wb_sel != 4'h0))
      r_data <= wb.wb_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_crc   <= INIT;
      r_sel   <= 4'h0;
      r_cnt   <= 16'h0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_dat_o <= 32'h0;
`ifndef WB_CRC32_FAST_EN
      r_bit   <= 3'd0;
`endif
    end else begin
      r_ack   <= w_accept;
      r_dat_o <= 32'h0;

      if (w_accept) begin
        if (wb.wb_we) begin
          case (w_reg)
            2'd0: if (wb.wb_dat_i[0]) begin
              r_crc <= INIT;
              r_cnt <= 16'h0;
            end
            2'd1: if (wb.wb_sel != 4'h0) begin
              r_sel   <= wb.wb_sel;
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
`ifndef WB_CRC32_FAST_EN
              r_bit   <= 3'd0;
`endif
            end
            2'd2: r_crc <= wb.wb_dat_i;
            default: ;
          endcase
        end else begin
          case (w_reg)
            2'd2:    r_dat_o <= r_crc ^ XOR_OUT;
            2'd3:    r_dat_o <= {r_cnt, 15'h0, r_busy};
            default: r_dat_o <= 32'h0;
          endcase
        end
      end

      // Writes stall while shifting, so the engine never races a bus write.
      if (r_state == S_SHIFT) begin
`ifdef WB_CRC32_FAST_EN
        r_crc <= crc_byte(r_crc, w_byte);
        r_cnt <= r_cnt + 16'd1;
        r_sel <= w_sel_next;
        if (w_sel_next == 4'h0) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
`else
        r_crc <= crc_bit(r_crc, w_byte[r_bit]);
        r_bit <= r_bit + 3'd1;
        if (r_bit == 3'd7) begin
          r_cnt <= r_cnt + 16'd1;
          r_sel <= w_sel_next;
          if (w_sel_next == 4'h0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule
